dmem_mc_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_be_ram.sv | 26 ++
 rtl/dmem_mc_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_mc_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store interface and the responder FSM.
package dmem_pkg;

    localparam logic [2:0] RC_LW  = 3'd0;
    localparam logic [2:0] RC_LH  = 3'd1;
    localparam logic [2:0] RC_LHU = 3'd2;
    localparam logic [2:0] RC_LB  = 3'd3;
    localparam logic [2:0] RC_LBU = 3'd4;

    localparam logic [1:0] WC_SW = 2'd0;
    localparam logic [1:0] WC_SH = 2'd1;
    localparam logic [1:0] WC_SB = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Access width in bytes; any code not listed behaves as a word access.
    function automatic logic [2:0] access_bytes(input logic is_store,
                                                input logic [2:0] rc,
                                                input logic [1:0] wc);
        logic [2:0] n;
        n = 3'd4;
        if (is_store) begin
            case (wc)
                WC_SH:   n = 3'd2;
                WC_SB:   n = 3'd1;
                default: n = 3'd4;
            endcase
        end else begin
            case (rc)
                RC_LH, RC_LHU: n = 3'd2;
                RC_LB, RC_LBU: n = 3'd1;
                default:       n = 3'd4;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/dmem_be_ram.sv
// Word-organised RAM with per-byte write enables, synchronous write and combinational read.
module dmem_be_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_mc_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, inserts wait states,
// then performs the access and returns a one-cycle done pulse with registered results.
module dmem_mc_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  readcontrol,
    input  logic [1:0]  writecontrol,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          go_resp;

    logic          lat_we;
    logic [AW+1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [2:0]    lat_rc;
    logic [1:0]    lat_wc;

    logic          acc_we;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [2:0]    acc_rc;
    logic [1:0]    acc_wc;

    logic [2:0]    size;
    logic          misaligned;
    logic [3:0]    be;
    logic [31:0]   lane_wdata;
    logic [31:0]   ram_rdata;
    logic          ram_we;
    logic [15:0]   half_lane;
    logic [7:0]    byte_lane;
    logic [31:0]   load_val;

    logic          unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    always_comb begin
        state_next = state;
        go_resp    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = S_RESP;
                        go_resp    = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == LAST) begin
                    state_next = S_RESP;
                    go_resp    = 1'b1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // With no wait states the access fires on the accept edge, so it must use the live request.
    always_comb begin
        if (state == S_IDLE) begin
            acc_we    = we;
            acc_addr  = addr[AW+1:0];
            acc_wdata = wdata;
            acc_rc    = readcontrol;
            acc_wc    = writecontrol;
        end else begin
            acc_we    = lat_we;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
            acc_rc    = lat_rc;
            acc_wc    = lat_wc;
        end
    end

    assign size       = access_bytes(acc_we, acc_rc, acc_wc);
    assign misaligned = ((size == 3'd4) && (acc_addr[1:0] != 2'b00)) ||
                        ((size == 3'd2) && acc_addr[0]);

    always_comb begin
        be         = 4'b1111;
        lane_wdata = acc_wdata;
        case (size)
            3'd2: begin
                be         = acc_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{acc_wdata[15:0]}};
            end
            3'd1: begin
                be         = 4'b0001 << acc_addr[1:0];
                lane_wdata = {4{acc_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        half_lane = acc_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        byte_lane = ram_rdata[{acc_addr[1:0], 3'b000} +: 8];
        case (acc_rc)
            RC_LH:   load_val = {{16{half_lane[15]}}, half_lane};
            RC_LHU:  load_val = {16'h0000, half_lane};
            RC_LB:   load_val = {{24{byte_lane[7]}}, byte_lane};
            RC_LBU:  load_val = {24'h000000, byte_lane};
            default: load_val = ram_rdata;
        endcase
    end

    // Reset gates the write so an edge seen while reset is held can never commit a store.
    assign ram_we = go_resp && acc_we && !misaligned && !reset;

    dmem_be_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .be   (be),
        .addr (acc_addr[AW+1:2]),
        .wdata(lane_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= ((state == S_WAIT) && (cnt != LAST)) ? cnt + 1'b1 : '0;
            ready <= (state_next == S_IDLE);
            done  <= go_resp;
            rdata <= (go_resp && !acc_we && !misaligned) ? load_val : '0;
            err   <= go_resp && misaligned;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_rc    <= RC_LW;
            lat_wc    <= WC_SW;
        end else if ((state == S_IDLE) && req) begin
            lat_we    <= we;
            lat_addr  <= addr[AW+1:0];
            lat_wdata <= wdata;
            lat_rc    <= readcontrol;
            lat_wc    <= writecontrol;
        end
    end

endmodule

// File: tb/tb_dmem_mc_responder.sv
// Scoreboard bench: a byte-array memory model predicts each response; a negedge monitor checks it.
module tb_dmem_mc_responder;
    import dmem_pkg::*;

    localparam int WT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [2:0]  readcontrol;
    logic [1:0]  writecontrol;
    logic        ready, done, err;
    logic [31:0] rdata;

    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic [2:0]  rc0;
    logic [1:0]  wc0;
    logic        ready0, done0, err0;
    logic [31:0] rdata0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_accept = 0;
    bit req_held    = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          done_cyc;
    } expect_t;

    expect_t    sbq[$];
    expect_t    mon_e;
    logic [7:0] model_mem [256];

    dmem_mc_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(WT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .readcontrol(readcontrol), .writecontrol(writecontrol),
        .ready(ready), .done(done), .rdata(rdata), .err(err)
    );

    dmem_mc_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .readcontrol(rc0), .writecontrol(wc0),
        .ready(ready0), .done(done0), .rdata(rdata0), .err(err0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic int accessBytes(input logic w, input logic [2:0] rc, input logic [1:0] wc);
        if (w) return (wc == WC_SH) ? 2 : (wc == WC_SB) ? 1 : 4;
        return (rc == RC_LH || rc == RC_LHU) ? 2 : (rc == RC_LB || rc == RC_LBU) ? 1 : 4;
    endfunction

    // Memory seen as 256 little-endian bytes; upper address bits simply wrap.
    function automatic expect_t modelAccess(input logic w, input logic [31:0] a, input logic [31:0] d,
                                            input logic [2:0] rc, input logic [1:0] wc);
        expect_t     e;
        int          n;
        int          base;
        logic [31:0] v;
        n          = accessBytes(w, rc, wc);
        base       = int'(a[7:0]);
        v          = 32'h0;
        e.rdata    = 32'h0;
        e.err      = (base % n) != 0;
        e.done_cyc = 0;
        if (e.err) return e;
        if (w) begin
            for (int i = 0; i < n; i++) model_mem[base + i] = d[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) v = v | (32'(model_mem[base + i]) << (8 * i));
            if (rc == RC_LH && v[15]) v = v | 32'hFFFF0000;
            if (rc == RC_LB && v[7])  v = v | 32'hFFFFFF00;
            e.rdata = v;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected done: got done=1 at cycle %0d, expected no pending access", cyc);
            end else begin
                mon_e = sbq.pop_front();
                checkOutput("rdata", rdata, mon_e.rdata);
                checkOutput("err", 32'(err), 32'(mon_e.err));
                checkOutput("done latency", cyc, mon_e.done_cyc);
            end
        end else if (!reset && sbq.size() > 0 && cyc > sbq[0].done_cyc) begin
            mon_e = sbq.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing done: got none by cycle %0d, expected at %0d", cyc, mon_e.done_cyc);
        end
    end

    // Called on a negedge; returns on the negedge after the accept edge with req still high.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] rc, input logic [1:0] wc);
        expect_t e;
        int      polls;
        req = 1'b1; we = w; addr = a; wdata = d; readcontrol = rc; writecontrol = wc;
        polls = 0;
        while (ready !== 1'b1 && polls < 64) begin
            @(negedge clk);
            polls++;
        end
        if (ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept timeout: got ready=%b after %0d cycles, expected 1", ready, polls);
            req = 1'b0;
            req_held = 1'b0;
            return;
        end
        if (req_held) checkOutput("back-to-back spacing", cyc - last_accept, WT + 2);
        last_accept = cyc;
        req_held    = 1'b1;
        e           = modelAccess(w, a, d, rc, wc);
        e.done_cyc  = cyc + WT + 1;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idleGap(input int n);
        req = 1'b0;
        req_held = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic waitDrain();
        int polls;
        polls = 0;
        while (sbq.size() > 0 && polls < 64) begin
            @(negedge clk);
            polls++;
        end
        if (sbq.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain timeout: got %0d pending, expected 0", sbq.size());
        end
    endtask

    // Zero-wait instance with req held high: one done every second cycle.
    task automatic dut0Step(input string name, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] rc, input logic [1:0] wc, input logic [31:0] exp);
        checkOutput({name, " ready"}, 32'(ready0), 32'd1);
        checkOutput({name, " idle done"}, 32'(done0), 32'd0);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; rc0 = rc; wc0 = wc;
        @(negedge clk);
        checkOutput({name, " done"}, 32'(done0), 32'd1);
        checkOutput({name, " rdata"}, rdata0, exp);
        checkOutput({name, " err"}, 32'(err0), 32'd0);
        checkOutput({name, " busy"}, 32'(ready0), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic        w;
        logic [31:0] a;
        logic [2:0]  rc;
        logic [1:0]  wc;
        int          n;

        reset = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; readcontrol = RC_LW; writecontrol = WC_SW;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; rc0 = RC_LW; wc0 = WC_SW;
        @(negedge clk);
        checkOutput("reset ready", 32'(ready), 32'd1);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset rdata", rdata, 32'h0);
        checkOutput("reset err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 32'(i * 4), $urandom, RC_LW, WC_SW);

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, RC_LW, WC_SW);
        applyStimulus(1'b0, 32'h10, 32'h0, RC_LW, WC_SW);
        idleGap(2);
        applyStimulus(1'b1, 32'h13, 32'h00000080, RC_LW, WC_SB);
        applyStimulus(1'b0, 32'h13, 32'h0, RC_LB, WC_SW);
        applyStimulus(1'b0, 32'h13, 32'h0, RC_LBU, WC_SW);
        applyStimulus(1'b0, 32'h10, 32'h0, RC_LW, WC_SW);
        applyStimulus(1'b1, 32'h12, 32'h00001234, RC_LW, WC_SH);
        applyStimulus(1'b0, 32'h12, 32'h0, RC_LH, WC_SW);
        applyStimulus(1'b0, 32'h10, 32'h0, RC_LHU, WC_SW);
        applyStimulus(1'b0, 32'h10, 32'h0, RC_LH, WC_SW);
        applyStimulus(1'b0, 32'h11, 32'h0, RC_LW, WC_SW);
        applyStimulus(1'b1, 32'h13, 32'hFFFFFFFF, RC_LW, WC_SH);
        applyStimulus(1'b0, 32'h10, 32'h0, RC_LW, WC_SW);
        applyStimulus(1'b1, 32'h100, 32'h0BADCAFE, RC_LW, WC_SW);
        applyStimulus(1'b0, 32'h0, 32'h0, RC_LW, WC_SW);

        for (int i = 0; i < 200; i++) begin
            w  = 1'($urandom_range(0, 1));
            rc = 3'($urandom_range(0, 7));
            wc = 2'($urandom_range(0, 3));
            a  = $urandom;
            n  = accessBytes(w, rc, wc);
            if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
            applyStimulus(w, a, $urandom, rc, wc);
            if ($urandom_range(0, 3) == 0) idleGap($urandom_range(1, 3));
        end

        idleGap(1);
        waitDrain();

        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55; readcontrol = RC_LW; writecontrol = WC_SW;
        @(negedge clk);
        req = 1'b0;
        checkOutput("abort in wait ready", 32'(ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset ready", 32'(ready), 32'd1);
        checkOutput("async reset done", 32'(done), 32'd0);
        checkOutput("async reset rdata", rdata, 32'h0);
        checkOutput("async reset err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req_held = 1'b0;
        applyStimulus(1'b0, 32'h20, 32'h0, RC_LW, WC_SW);
        idleGap(1);
        waitDrain();

        dut0Step("w0 sw alias", 1'b1, 32'h100, 32'hCAFEF00D, RC_LW, WC_SW, 32'h00000000);
        dut0Step("w0 lw alias", 1'b0, 32'h000, 32'h0, RC_LW, WC_SW, 32'hCAFEF00D);
        dut0Step("w0 sb",       1'b1, 32'h101, 32'h0000005A, RC_LW, WC_SB, 32'h00000000);
        dut0Step("w0 lw",       1'b0, 32'h100, 32'h0, RC_LW, WC_SW, 32'hCAFE5A0D);
        dut0Step("w0 lbu",      1'b0, 32'h001, 32'h0, RC_LBU, WC_SW, 32'h0000005A);
        dut0Step("w0 lh",       1'b0, 32'h002, 32'h0, RC_LH, WC_SW, 32'hFFFFCAFE);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
